// File: rtl/high_low_game_pkg.sv
// Shared definitions for the high/low guessing game: state codes, seed width,
// guess-result record and the guess comparison helper.
package high_low_game_pkg;

    localparam int MAX_GUESSES_DEFAULT = 6;
    localparam int SEED_W              = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;
    localparam logic [1:0] ST_LOSE = 2'd3;

    localparam logic [SEED_W-1:0] SEED_RESET = 4'b0001;

    typedef struct packed {
        logic too_high;
        logic too_low;
        logic correct;
    } result_t;

    localparam result_t RESULT_NONE = '{too_high: 1'b0, too_low: 1'b0, correct: 1'b0};

    // Exactly one field is set for any pair of operands.
    function automatic result_t compare_guess(input logic [SEED_W-1:0] guess_i,
                                              input logic [SEED_W-1:0] target_i);
        result_t r;
        r.too_high = (guess_i > target_i);
        r.too_low  = (guess_i < target_i);
        r.correct  = (guess_i == target_i);
        return r;
    endfunction

endpackage

// File: rtl/high_low_game_lfsr.sv
// Combinational next-value function of the 4-bit maximal-length seed LFSR.
module high_low_game_lfsr
    import high_low_game_pkg::*;
(
    input  logic [SEED_W-1:0] seed_i,
    output logic [SEED_W-1:0] seed_next_o
);

    // Shift left, feed back the XOR of the two top taps; period 15, never 0.
    always_comb begin
        seed_next_o = {seed_i[2:0], seed_i[3] ^ seed_i[2]};
    end

endmodule

// File: rtl/high_low_game.sv
// High/low guessing game: a free-running seed becomes the hidden target on a
// new-game press; the player then has MAX_GUESSES tries to hit it.
module high_low_game
    import high_low_game_pkg::*;
#(
    parameter int MAX_GUESSES = MAX_GUESSES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              newGame,
    input  logic              guessBtn,
    input  logic [SEED_W-1:0] guess,
    output logic              tooHigh,
    output logic              tooLow,
    output logic              correct,
    output logic [3:0]        guessCount,
    output logic              win,
    output logic              lose,
    output logic [SEED_W-1:0] target
);

    localparam logic [3:0] MAX_GUESSES_L = 4'(MAX_GUESSES);

    logic [SEED_W-1:0] seed_q, seed_d;
    logic              new_game_btn_q, new_game_btn_d;
    logic              guess_btn_q, guess_btn_d;
    logic [1:0]        state_q, state_d;
    logic [SEED_W-1:0] target_q, target_d;
    logic [3:0]        count_q, count_d;
    result_t           result_q, result_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;

    logic              new_game_edge_s;
    logic              guess_edge_s;
    logic [3:0]        count_inc_s;
    result_t           guess_result_s;

    high_low_game_lfsr u_lfsr (
        .seed_i      (seed_q),
        .seed_next_o (seed_d)
    );

    // Button edge detection and guess evaluation against the held target.
    always_comb begin
        new_game_btn_d  = newGame;
        guess_btn_d     = guessBtn;
        new_game_edge_s = newGame & ~new_game_btn_q;
        guess_edge_s    = guessBtn & ~guess_btn_q;
        count_inc_s     = count_q + 4'd1;
        guess_result_s  = compare_guess(guess, target_q);
    end

    // Game FSM; a new-game press overrides any simultaneous guess.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        result_d = result_q;
        if (new_game_edge_s) begin
            state_d  = ST_PLAY;
            target_d = seed_q;
            count_d  = 4'd0;
            result_d = RESULT_NONE;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (guess_edge_s) begin
                        result_d = guess_result_s;
                        count_d  = count_inc_s;
                        if (guess_result_s.correct) begin
                            state_d = ST_WIN;
                        end else if (count_inc_s == MAX_GUESSES_L) begin
                            state_d = ST_LOSE;
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d  = ST_IDLE;
                    count_d  = 4'd0;
                    result_d = RESULT_NONE;
                end
            endcase
        end
    end

    // Game-over indicators follow the next state so they register alongside it.
    always_comb begin
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    // State registers; reset aborts any game in progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_q         <= SEED_RESET;
            new_game_btn_q <= 1'b0;
            guess_btn_q    <= 1'b0;
            state_q        <= ST_IDLE;
            target_q       <= 4'b0000;
            count_q        <= 4'd0;
            result_q       <= RESULT_NONE;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
        end else begin
            seed_q         <= seed_d;
            new_game_btn_q <= new_game_btn_d;
            guess_btn_q    <= guess_btn_d;
            state_q        <= state_d;
            target_q       <= target_d;
            count_q        <= count_d;
            result_q       <= result_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
        end
    end

    assign tooHigh    = result_q.too_high;
    assign tooLow     = result_q.too_low;
    assign correct    = result_q.correct;
    assign guessCount = count_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign target     = target_q;

endmodule

// File: tb/tb_high_low_game.sv
// Self-checking bench for high_low_game: directed scenarios with literal
// expectations plus randomized play against a behavioural game model.
module tb_high_low_game;

    localparam int MAXG = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       newGame;
    logic       guessBtn;
    logic [3:0] guess;
    logic       tooHigh, tooLow, correct, win, lose;
    logic [3:0] guessCount, target;

    int vectors     = 0;
    int miscompares = 0;

    high_low_game #(.MAX_GUESSES(MAXG)) dut (
        .clk        (clk),
        .reset      (reset),
        .newGame    (newGame),
        .guessBtn   (guessBtn),
        .guess      (guess),
        .tooHigh    (tooHigh),
        .tooLow     (tooLow),
        .correct    (correct),
        .guessCount (guessCount),
        .win        (win),
        .lose       (lose),
        .target     (target)
    );

    always #5 clk = ~clk;

    // Behavioural game model: seed is the n-th entry of the known 15-long cycle.
    localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;
    int seed_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int m_mode, m_idx, m_target, m_count;
    int m_hi, m_lo, m_eq;
    bit m_ng_prev, m_gb_prev;

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_target = 0; m_count = 0;
        m_hi = 0; m_lo = 0; m_eq = 0;
        m_ng_prev = 1'b0; m_gb_prev = 1'b0;
    endtask

    task automatic model_step();
        bit ng_rise, gb_rise;
        int g;
        ng_rise = newGame && !m_ng_prev;
        gb_rise = guessBtn && !m_gb_prev;
        g = int'(guess);
        if (ng_rise) begin
            m_target = seed_seq[m_idx];
            m_count = 0; m_hi = 0; m_lo = 0; m_eq = 0;
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY && gb_rise) begin
            m_hi = (g > m_target) ? 1 : 0;
            m_lo = (g < m_target) ? 1 : 0;
            m_eq = (g == m_target) ? 1 : 0;
            m_count = m_count + 1;
            if (g == m_target) m_mode = M_WIN;
            else if (m_count == MAXG) m_mode = M_LOSE;
        end
        m_ng_prev = newGame;
        m_gb_prev = guessBtn;
        m_idx = (m_idx + 1) % 15;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("target",     int'(target),     m_target);
        chk("guessCount", int'(guessCount), m_count);
        chk("tooHigh",    int'(tooHigh),    m_hi);
        chk("tooLow",     int'(tooLow),     m_lo);
        chk("correct",    int'(correct),    m_eq);
        chk("win",        int'(win),        (m_mode == M_WIN)  ? 1 : 0);
        chk("lose",       int'(lose),       (m_mode == M_LOSE) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
        compare_all();
    endtask

    task automatic press(input logic [3:0] g);
        guess = g; guessBtn = 1'b1;
        tick();
        guessBtn = 1'b0;
        tick();
    endtask

    task automatic start_game();
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        tick();
    endtask

    // Called just after a rising edge: drop reset between edges, check at once.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] wrong;
        reset = 1'b0; newGame = 1'b0; guessBtn = 1'b0; guess = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_target", int'(target), 0);
        reset = 1'b1;

        // Seed walks 0001,0010,0100,1001; the 4th edge captures 1001.
        tick(); tick(); tick();
        newGame = 1'b1;
        tick();
        chk("first_target", int'(target), 9);
        newGame = 1'b0;
        tick();

        press(4'b0100);
        chk("g1_tooLow", int'(tooLow), 1);
        press(4'b1100);
        chk("g2_tooHigh", int'(tooHigh), 1);
        press(4'b1001);
        chk("g3_correct", int'(correct), 1);
        chk("g3_win", int'(win), 1);
        chk("g3_count", int'(guessCount), 3);

        // Six wrong guesses lose; a further guess is ignored.
        start_game();
        press(4'b0000);
        chk("zero_tooLow", int'(tooLow), 1);
        wrong = 4'(m_target) ^ 4'b0001;
        repeat (5) press(wrong);
        chk("lose_flag", int'(lose), 1);
        chk("lose_count", int'(guessCount), 6);
        press(4'(m_target));
        chk("after_lose_count", int'(guessCount), 6);
        chk("after_lose_win", int'(win), 0);
        chk("after_lose_correct", int'(correct), 0);

        // Held guess button counts once.
        start_game();
        guess = 4'(m_target) ^ 4'b0010;
        guessBtn = 1'b1;
        repeat (10) tick();
        chk("held_count", int'(guessCount), 1);
        guessBtn = 1'b0;
        tick();

        // Simultaneous edges: new game wins, guess discarded.
        newGame = 1'b1; guessBtn = 1'b1;
        tick();
        chk("simul_count", int'(guessCount), 0);
        chk("simul_flags", int'(tooHigh) + int'(tooLow) + int'(correct), 0);
        newGame = 1'b0; guessBtn = 1'b0;
        tick();

        // Mid-game asynchronous reset with two guesses made.
        wrong = 4'(m_target) ^ 4'b0100;
        press(wrong);
        press(wrong);
        chk("pre_rst_count", int'(guessCount), 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_count", int'(guessCount), 0);
        chk("arst_target", int'(target), 0);
        chk("arst_outs", int'(tooHigh) + int'(tooLow) + int'(correct) + int'(win) + int'(lose), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(); tick(); tick();
        newGame = 1'b1;
        tick();
        chk("reseed_target", int'(target), 9);
        newGame = 1'b0;
        tick();

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            newGame  = ($urandom_range(0, 29) == 0);
            guessBtn = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) guess = 4'(m_target);
            else guess = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
